// File: rtl/forward_scoreboard_if.sv
// rtl/forward_scoreboard_if.sv - operand forwarding / hazard scoreboard bus bundle
//
// Ports (master = pipeline side, slave = forward_scoreboard):
//   decode_rs_addr      packed source addresses, port i at [i*AW +: AW]
//   regs_rs_rd_data     packed register-file read data
//   forward_rs_data     packed forwarded operands
//   execute_force_stall stall request to Execute
//   execute_rd*, memory_clk_en   Execute/Memory producer
//   wb_rd*, wb_long              Memory/Writeback producer
//   long_issue_en/rd/ready       long-latency issue handshake
//   sb_underflow        sticky completion-without-pending flag
//   stall_cycles        saturating stall cycle count
interface forward_scoreboard_if #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int STALL_CNT_W  = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD_PORTS*AW-1:0]   decode_rs_addr;
    logic [NUM_RD_PORTS*XLEN-1:0] regs_rs_rd_data;
    logic [NUM_RD_PORTS*XLEN-1:0] forward_rs_data;
    logic                         execute_force_stall;
    logic [AW-1:0]                execute_rd;
    logic                         execute_rd_wr_en;
    logic [XLEN-1:0]              execute_rd_wr_data;
    logic                         execute_rd_valid;
    logic                         memory_clk_en;
    logic [AW-1:0]                wb_rd;
    logic                         wb_rd_wr_en;
    logic [XLEN-1:0]              wb_rd_wr_data;
    logic                         wb_long;
    logic                         long_issue_en;
    logic [AW-1:0]                long_issue_rd;
    logic                         long_issue_ready;
    logic                         sb_underflow;
    logic [STALL_CNT_W-1:0]       stall_cycles;

    modport master (
        output decode_rs_addr, regs_rs_rd_data,
        output execute_rd, execute_rd_wr_en, execute_rd_wr_data, execute_rd_valid, memory_clk_en,
        output wb_rd, wb_rd_wr_en, wb_rd_wr_data, wb_long,
        output long_issue_en, long_issue_rd,
        input  forward_rs_data, execute_force_stall, long_issue_ready, sb_underflow, stall_cycles
    );

    modport slave (
        input  decode_rs_addr, regs_rs_rd_data,
        input  execute_rd, execute_rd_wr_en, execute_rd_wr_data, execute_rd_valid, memory_clk_en,
        input  wb_rd, wb_rd_wr_en, wb_rd_wr_data, wb_long,
        input  long_issue_en, long_issue_rd,
        output forward_rs_data, execute_force_stall, long_issue_ready, sb_underflow, stall_cycles
    );
endinterface

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - operand forwarding and long-latency hazard scoreboard
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    forward_scoreboard_if.slave (see interface file for signal list)
//
// Build option: FORWARD_STALL_CNT_EN - when defined, bus.stall_cycles is a
// saturating count of stalled cycles; otherwise it is tied to zero.
module forward_scoreboard #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int PEND_W       = 2,
    parameter int STALL_CNT_W  = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    forward_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // pend[0] is held at zero: x0 is never tracked.
    logic [PEND_W-1:0]            pend [NUM_REGS];
    logic                         complete;
    logic                         issue_ready;
    logic                         issue_fire;
    logic [NUM_REGS-1:0]          inc_vec;
    logic [NUM_REGS-1:0]          dec_vec;
    logic [AW-1:0]                rs_a;
    logic [NUM_RD_PORTS*XLEN-1:0] fwd;
    logic                         stall;
    logic                         underflow;

    assign complete = bus.wb_rd_wr_en & bus.wb_long & (bus.wb_rd != '0);

    // A completion on the same register frees a slot in the same cycle.
    assign issue_ready = (bus.long_issue_rd == '0)
                       | (pend[bus.long_issue_rd] != PEND_MAX)
                       | (complete & (bus.wb_rd == bus.long_issue_rd));
    assign issue_fire  = bus.long_issue_en & issue_ready & (bus.long_issue_rd != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_fire & (bus.long_issue_rd == AW'(r));
            dec_vec[r] = complete & (bus.wb_rd == AW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
            underflow <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend[r] <= pend[r] + PEND_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (pend[r] != '0) begin
                        pend[r] <= pend[r] - PEND_W'(1);
                    end else begin
                        underflow <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-port resolution: x0, then EX/MEM, then MEM/WB, then scoreboard, then RF.
    always_comb begin
        fwd   = '0;
        stall = 1'b0;
        rs_a  = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            rs_a = bus.decode_rs_addr[i*AW +: AW];
            if (rs_a == '0) begin
                fwd[i*XLEN +: XLEN] = '0;
            end else if (bus.execute_rd_wr_en && bus.memory_clk_en && bus.execute_rd == rs_a) begin
                fwd[i*XLEN +: XLEN] = bus.execute_rd_wr_data;
                if (!bus.execute_rd_valid) stall = 1'b1;
            end else if (bus.wb_rd_wr_en && bus.wb_rd == rs_a) begin
                fwd[i*XLEN +: XLEN] = bus.wb_rd_wr_data;
                // On a WB hit, wb_long means this write retires one pending op on rs_a;
                // anything left over is a younger long op still in flight.
                if (pend[rs_a] > PEND_W'(bus.wb_long)) stall = 1'b1;
            end else begin
                fwd[i*XLEN +: XLEN] = bus.regs_rs_rd_data[i*XLEN +: XLEN];
                if (pend[rs_a] != '0) stall = 1'b1;
            end
        end
    end

    assign bus.forward_rs_data     = fwd;
    assign bus.execute_force_stall = stall;
    assign bus.long_issue_ready    = issue_ready;
    assign bus.sb_underflow        = underflow;

`ifdef FORWARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - self-checking bench for forward_scoreboard
module tb_forward_scoreboard;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NP   = 2;
    localparam int AW   = 5;
    localparam int PMAX = 3;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    // reference model state
    int          m_pend [NREG];
    logic        m_uf;
    logic [31:0] m_scnt;
    logic [63:0] e_fwd;
    logic        e_stall;
    logic        e_ready;

    forward_scoreboard_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP), .STALL_CNT_W(32)) bus();

    forward_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP), .PEND_W(2), .STALL_CNT_W(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.decode_rs_addr     = '0;
        bus.regs_rs_rd_data    = '0;
        bus.execute_rd         = '0;
        bus.execute_rd_wr_en   = 1'b0;
        bus.execute_rd_wr_data = '0;
        bus.execute_rd_valid   = 1'b1;
        bus.memory_clk_en      = 1'b1;
        bus.wb_rd              = '0;
        bus.wb_rd_wr_en        = 1'b0;
        bus.wb_rd_wr_data      = '0;
        bus.wb_long            = 1'b0;
        bus.long_issue_en      = 1'b0;
        bus.long_issue_rd      = '0;
    endtask

    task automatic set_ports(input int a0, input int a1);
        bus.decode_rs_addr = {AW'(a1), AW'(a0)};
    endtask

    // Expected outputs from the architectural rules: freshest producer wins,
    // a source register with outstanding long ops is not yet usable.
    task automatic model_eval();
        int a;
        int wb_retire;
        logic [31:0] d;
        e_fwd   = '0;
        e_stall = 1'b0;
        for (int i = 0; i < NP; i++) begin
            a = int'(bus.decode_rs_addr[i*AW +: AW]);
            if (a == 0) begin
                d = 32'h0;
            end else if (bus.execute_rd_wr_en && bus.memory_clk_en && int'(bus.execute_rd) == a) begin
                d = bus.execute_rd_wr_data;
                if (!bus.execute_rd_valid) e_stall = 1'b1;
            end else if (bus.wb_rd_wr_en && int'(bus.wb_rd) == a) begin
                d = bus.wb_rd_wr_data;
                wb_retire = bus.wb_long ? 1 : 0;
                if (m_pend[a] - wb_retire > 0) e_stall = 1'b1;
            end else begin
                d = bus.regs_rs_rd_data[i*XLEN +: XLEN];
                if (m_pend[a] > 0) e_stall = 1'b1;
            end
            e_fwd[i*XLEN +: XLEN] = d;
        end
        e_ready = (bus.long_issue_rd == 0) || (m_pend[bus.long_issue_rd] < PMAX) ||
                  (bus.wb_rd_wr_en && bus.wb_long && bus.wb_rd == bus.long_issue_rd);
    endtask

    task automatic model_update();
        int  ir;
        int  cr;
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            m_uf   = 1'b0;
            m_scnt = 32'h0;
        end else begin
            ir = (bus.long_issue_en && e_ready && bus.long_issue_rd != 0) ? int'(bus.long_issue_rd) : 0;
            cr = (bus.wb_rd_wr_en && bus.wb_long && bus.wb_rd != 0) ? int'(bus.wb_rd) : 0;
            if (ir != 0 && ir == cr) begin
                // issue and completion cancel out
            end else begin
                if (ir != 0) m_pend[ir] = m_pend[ir] + 1;
                if (cr != 0) begin
                    if (m_pend[cr] == 0) m_uf = 1'b1;
                    else m_pend[cr] = m_pend[cr] - 1;
                end
            end
            if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        end
    endtask

    function automatic logic [31:0] exp_scnt(input logic [31:0] v);
`ifdef FORWARD_STALL_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic settle();
        #1;
        model_eval();
        chk("fwd_data", bus.forward_rs_data, e_fwd);
        chk("stall", 64'(bus.execute_force_stall), 64'(e_stall));
        chk("issue_ready", 64'(bus.long_issue_ready), 64'(e_ready));
        chk("underflow", 64'(bus.sb_underflow), 64'(m_uf));
        chk("stall_cycles", 64'(bus.stall_cycles), 64'(exp_scnt(m_scnt)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        m_uf   = 1'b0;
        m_scnt = 32'h0;
        e_stall = 1'b0;
        e_ready = 1'b1;
        e_fwd  = '0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state, x5 from RF on port 0, x0 on port 1
        set_ports(5, 0);
        bus.regs_rs_rd_data = {32'h9999_9999, 32'h0000_1234};
        settle();
        chk("rst_fwd", bus.forward_rs_data, 64'h0000_0000_0000_1234);
        chk("rst_stall", 64'(bus.execute_force_stall), 64'd0);
        chk("rst_scnt", 64'(bus.stall_cycles), 64'd0);
        chk("rst_uf", 64'(bus.sb_underflow), 64'd0);
        tick();

        // EX beats WB on the same register
        idle();
        set_ports(7, 7);
        bus.execute_rd = 5'd7; bus.execute_rd_wr_en = 1'b1; bus.execute_rd_wr_data = 32'hAAAA_0001;
        bus.wb_rd = 5'd7; bus.wb_rd_wr_en = 1'b1; bus.wb_rd_wr_data = 32'h5;
        settle();
        chk("ex_fwd", bus.forward_rs_data, 64'hAAAA_0001_AAAA_0001);
        chk("ex_stall", 64'(bus.execute_force_stall), 64'd0);
        tick();

        // LOAD to x3, dependent read stalls, completion forwards and clears
        idle();
        bus.long_issue_en = 1'b1; bus.long_issue_rd = 5'd3;
        settle();
        chk("ld_ready", 64'(bus.long_issue_ready), 64'd1);
        tick();
        idle();
        set_ports(3, 0);
        settle();
        chk("ld_stall", 64'(bus.execute_force_stall), 64'd1);
        tick();
        bus.wb_rd = 5'd3; bus.wb_rd_wr_en = 1'b1; bus.wb_long = 1'b1; bus.wb_rd_wr_data = 32'hDEAD_BEEF;
        settle();
        chk("ld_wb_fwd", 64'(bus.forward_rs_data[31:0]), 64'hDEAD_BEEF);
        chk("ld_wb_stall", 64'(bus.execute_force_stall), 64'd0);
        tick();
        idle();
        set_ports(3, 0);
        settle();
        chk("ld_cleared", 64'(bus.execute_force_stall), 64'd0);
        tick();

        // saturate x9
        idle();
        bus.long_issue_en = 1'b1; bus.long_issue_rd = 5'd9;
        for (int k = 0; k < 3; k++) step();
        settle();
        chk("sat_ready", 64'(bus.long_issue_ready), 64'd0);
        tick();
        bus.wb_rd = 5'd9; bus.wb_rd_wr_en = 1'b1; bus.wb_long = 1'b1; bus.wb_rd_wr_data = 32'h77;
        settle();
        chk("sat_swap_ready", 64'(bus.long_issue_ready), 64'd1);
        tick();
        bus.wb_rd_wr_en = 1'b0; bus.wb_long = 1'b0;
        settle();
        chk("sat_still3", 64'(bus.long_issue_ready), 64'd0);
        tick();
        idle();
        bus.wb_rd = 5'd9; bus.wb_rd_wr_en = 1'b1; bus.wb_long = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // completion with nothing pending on x4
        idle();
        bus.wb_rd = 5'd4; bus.wb_rd_wr_en = 1'b1; bus.wb_long = 1'b1;
        step();
        idle();
        step();
        step();
        settle();
        chk("uf_sticky", 64'(bus.sb_underflow), 64'd1);
        tick();

        // reset clears, then hold a stall for five cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        chk("uf_cleared", 64'(bus.sb_underflow), 64'd0);
        idle();
        set_ports(2, 0);
        bus.execute_rd = 5'd2; bus.execute_rd_wr_en = 1'b1; bus.execute_rd_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        idle();
        settle();
`ifdef FORWARD_STALL_CNT_EN
        chk("scnt_5", 64'(bus.stall_cycles), 64'd5);
`else
        chk("scnt_5", 64'(bus.stall_cycles), 64'd0);
`endif
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            set_ports($urandom_range(0, 7), $urandom_range(0, 7));
            bus.regs_rs_rd_data    = {$urandom, $urandom};
            bus.execute_rd         = AW'($urandom_range(0, 7));
            bus.execute_rd_wr_en   = ($urandom_range(0, 2) == 0);
            bus.execute_rd_wr_data = $urandom;
            bus.execute_rd_valid   = ($urandom_range(0, 3) != 0);
            bus.memory_clk_en      = ($urandom_range(0, 4) != 0);
            bus.wb_rd              = AW'($urandom_range(0, 7));
            bus.wb_rd_wr_en        = ($urandom_range(0, 1) == 0);
            bus.wb_rd_wr_data      = $urandom;
            bus.wb_long            = ($urandom_range(0, 1) == 0);
            bus.long_issue_en      = ($urandom_range(0, 1) == 0);
            bus.long_issue_rd      = AW'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised operand-forwarding and hazard unit for the 5-stage RV32I pipeline. It sits between [Decode] and [Execute]. For each of NUM_RD_PORTS source operands it selects the freshest value from [Execute/Memory], [Memory/Writeback] or the register file. A per-register pending-write scoreboard tracks long-latency producers (LOAD, CSR) and drives `execute_force_stall` until their result can be forwarded.

## Interface
- `XLEN`, 32, data width.
- `NUM_REGS`, 32, architectural registers; `AW = $clog2(NUM_REGS)`.
- `NUM_RD_PORTS`, 2, source operands resolved per cycle.
- `PEND_W`, 2, width of each per-register pending counter; max outstanding per register = 2^PEND_W−1.
- `STALL_CNT_W`, 32, width of the stall performance counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `decode_rs_addr` in NUM_RD_PORTS*AW: packed source addresses; port i is at [i*AW +: AW].
- `regs_rs_rd_data` in NUM_RD_PORTS*XLEN: packed register-file read data.
- `forward_rs_data` out NUM_RD_PORTS*XLEN: packed forwarded operands.
- `execute_force_stall` out 1: stall [Execute].
- `execute_rd`, `execute_rd_wr_en`, `execute_rd_wr_data`, `execute_rd_valid`, `memory_clk_en` in AW/1/XLEN/1/1: the [Execute/Memory] producer. `execute_rd_valid` low means LOAD/CSR, whose result is not yet available.
- `wb_rd`, `wb_rd_wr_en`, `wb_rd_wr_data` in AW/1/XLEN: the [Memory/Writeback] producer.
- `wb_long` in 1: the current writeback completes a long-latency op.
- `long_issue_en` in 1, `long_issue_rd` in AW: a long-latency op is leaving [Execute].
- `long_issue_ready` out 1: the scoreboard can accept the issue.
- `sb_underflow` out 1: sticky error flag; a completion arrived for a register with no pending count.
- `stall_cycles` out STALL_CNT_W: saturating stall count.

## Operation
- Scoreboard state: `pend[r]` (PEND_W bits) for r = 1..NUM_REGS−1. Register x0 is never tracked.
- Issue is accepted when all of the following hold:
  - `long_issue_en`
  - `long_issue_ready`
  - `long_issue_rd != 0`
- Completion is `wb_rd_wr_en & wb_long & wb_rd != 0`.
- Per register, on each clock edge:
  - issue only: +1
  - completion only: −1
  - issue and completion on the same register: unchanged
  - completion when the count is 0: count unchanged, set `sb_underflow`
- `long_issue_ready = (pend[long_issue_rd] != max) | (completion on long_issue_rd this cycle)`. It is always 1 when `long_issue_rd == 0`.
- Per-port resolution for port i with address a, highest priority first:
  1. a == 0: forward 0. No stall.
  2. EX hit (`execute_rd_wr_en & memory_clk_en & execute_rd == a`): forward `execute_rd_wr_data`. Stall if `!execute_rd_valid`.
  3. WB hit (`wb_rd_wr_en & wb_rd == a`): forward `wb_rd_wr_data`. Stall if `pend[a] − (completion on a ? 1 : 0) > 0`, because a younger long op is still outstanding.
  4. `pend[a] != 0`: forward register-file data and stall.
  5. Otherwise forward `regs_rs_rd_data` for port i.
- `execute_force_stall` is the OR over all ports of the stall terms above.
- Every port resolves independently. Two ports with the same address receive identical data.

## Timing
- Forwarding mux and `execute_force_stall` are purely combinational from current inputs plus the registered `pend`: zero-cycle latency.
- An issue at edge N is visible in `pend` from cycle N+1. A same-cycle dependent read is covered by the EX-hit rule, not by the scoreboard.
- `long_issue_ready` is combinational.
- When the issue is refused (counter saturated), the issuer holds its request.
- Values during reset (`rst_n` low at an edge):
  - all `pend` = 0
  - `sb_underflow` = 0
  - `stall_cycles` = 0
- Comb outputs follow from cleared state. Reset in the middle of an outstanding op discards all pending counts. Later completions for those ops set `sb_underflow`.
- `stall_cycles` increments by 1 on each edge where `execute_force_stall` is 1, and holds at all-ones.

## Configuration
- `FORWARD_STALL_CNT_EN`:
  - Defined: the `stall_cycles` counter is present as described.
  - Undefined: no counter register; `stall_cycles` is tied to 0.
- Forwarding, stall and scoreboard behaviour is identical either way.

## Test plan
- Reset, then port 0 reads x5 and port 1 reads x0, with no hits and the register file returning 0x1234 → `forward_rs_data` = {0, 0x1234}, stall 0, `stall_cycles` 0.
- EX hit on x7 with `execute_rd_valid` = 1 and data 0xAAAA_0001, while WB writes x7 = 0x5 in the same cycle → both ports reading x7 get 0xAAAA_0001, no stall.
- Issue LOAD to x3; next cycle read x3 with no hit → stall 1. WB completes x3 with 0xDEAD_BEEF and `wb_long` set → forward 0xDEAD_BEEF, stall 0, `pend[3]` back to 0.
- Issue x9 three times (PEND_W = 2) → `long_issue_ready` goes 0 on the 4th request. Complete one and re-issue in the same cycle → ready 1, count stays 3.
- Completion for x4 with `pend[4]` = 0 → `sb_underflow` sticks at 1 until reset.
- Hold a stall for 5 cycles → `stall_cycles` = 5 with `FORWARD_STALL_CNT_EN` defined, 0 without it.
